// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch queue.
package fetch_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; push into a full FIFO is accepted when a pop happens in the same cycle.
module fetch_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CW'(DEPTH));
    assign o_count  = r_count;
    assign o_data   = r_mem[r_rptr];
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wptr <= r_wptr + AW'(1);
            if (w_doPop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_doPush) - CW'(w_doPop);
        end
    end

    // Storage needs no reset: only entries counted by r_count are ever read as valid.
    always_ff @(posedge clk) begin
        if (w_doPush && !i_flush) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch unit: owns the PC, issues credit-limited in-order imem requests and feeds decode from a small queue.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                 D_WIDTH  = 32,
    parameter int                 A_WIDTH  = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [A_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT[A_WIDTH-1:0]
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [A_WIDTH-1:0] imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [D_WIDTH-1:0] imem_rsp_data,
    output logic [D_WIDTH-1:0] InstrD,
    output logic [A_WIDTH-1:0] PCD,
    output logic [A_WIDTH-1:0] PCPlus4D,
    output logic               InstrValidD,
    input  logic               StallD,
    input  logic               Redirect,
    input  logic [A_WIDTH-1:0] RedirectTarget
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [A_WIDTH-1:0]         r_pc;
    logic [CW-1:0]              r_outstanding;
    logic [CW-1:0]              r_dropCnt;
    logic [CW-1:0]              w_outNext;
    logic [CW-1:0]              w_qCount;
    logic [CW-1:0]              w_tagCount;
    logic                       w_qEmpty;
    logic                       w_qFull;
    logic                       w_tagEmpty;
    logic                       w_tagFull;
    logic                       w_credit;
    logic                       w_reqFire;
    logic                       w_rspKeep;
    logic                       w_rspDrop;
    logic                       w_deq;
    logic [A_WIDTH-1:0]         w_tagPc;
    logic [D_WIDTH+A_WIDTH-1:0] w_head;
    logic [A_WIDTH-1:0]         w_headPc;
    logic                       w_unused;

    // Credit covers both queued and in-flight entries, so responses never need backpressure.
    assign w_credit       = ({1'b0, w_qCount} + {1'b0, r_outstanding}) < (CW+1)'(DEPTH);
    assign imem_req_valid = !rst && !Redirect && w_credit;
    assign imem_addr      = r_pc;
    assign w_reqFire      = imem_req_valid && imem_req_ready;
    assign w_rspKeep      = imem_rsp_valid && (r_dropCnt == '0);
    assign w_rspDrop      = imem_rsp_valid && (r_dropCnt != '0);
    assign w_outNext      = r_outstanding + CW'(w_reqFire) - CW'(imem_rsp_valid);
    assign w_deq          = InstrValidD && !StallD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_dropCnt     <= '0;
        end else begin
            r_outstanding <= w_outNext;
            if (Redirect) begin
                r_pc      <= RedirectTarget;
                r_dropCnt <= w_outNext;
            end else begin
                if (w_reqFire) r_pc      <= r_pc + A_WIDTH'(4);
                if (w_rspDrop) r_dropCnt <= r_dropCnt - CW'(1);
            end
        end
    end

    // Tags are never flushed; stale ones drain one-for-one with dropped responses.
    fetch_fifo #(.WIDTH(A_WIDTH), .DEPTH(DEPTH)) u_tagFifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_reqFire),
        .i_pop   (imem_rsp_valid),
        .i_flush (1'b0),
        .i_data  (r_pc),
        .o_data  (w_tagPc),
        .o_full  (w_tagFull),
        .o_empty (w_tagEmpty),
        .o_count (w_tagCount)
    );

    fetch_fifo #(.WIDTH(D_WIDTH + A_WIDTH), .DEPTH(DEPTH)) u_instrQueue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rspKeep),
        .i_pop   (w_deq),
        .i_flush (Redirect),
        .i_data  ({imem_rsp_data, w_tagPc}),
        .o_data  (w_head),
        .o_full  (w_qFull),
        .o_empty (w_qEmpty),
        .o_count (w_qCount)
    );

    assign w_headPc    = w_head[A_WIDTH-1:0];
    assign InstrValidD = !w_qEmpty;
    assign InstrD      = InstrValidD ? w_head[D_WIDTH+A_WIDTH-1:A_WIDTH] : D_WIDTH'(NOP_INSTR);
    assign PCD         = InstrValidD ? w_headPc : '0;
    assign PCPlus4D    = InstrValidD ? w_headPc + A_WIDTH'(4) : '0;

    assign w_unused = ^{w_qFull, w_tagFull, w_tagEmpty, w_tagCount};

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Producer end of the decode interface in the pipelined RV32I core.
- Owns the PC and issues in-order requests to instruction memory.
- Buffers returned instructions in a small queue and presents InstrD/PCD/PCPlus4D to the decode stage under a valid/stall handshake.
- Handles redirects from taken branches, JAL and JALR by flushing the queue and discarding in-flight stale responses.

Parameters:
- D_WIDTH, 32, instruction width.
- A_WIDTH, 32, address/PC width.
- DEPTH, 4, queue entries; must be a power of two, ≥2.
- RESET_PC, 32'h0000_0000, PC after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_addr  out  A_WIDTH  request address; equals the current PC.
- imem_rsp_valid  in  1  response valid. Responses are in order, at least 1 cycle after acceptance.
- imem_rsp_data  in  D_WIDTH  returned instruction.
- InstrD  out  D_WIDTH  head instruction; 32'h0000_0013 (NOP) when not valid.
- PCD  out  A_WIDTH  PC of the head instruction.
- PCPlus4D  out  A_WIDTH  PCD+4.
- InstrValidD  out  1  head entry valid.
- StallD  in  1  decode cannot accept this cycle.
- Redirect  in  1  flush and restart fetch.
- RedirectTarget  in  A_WIDTH  new PC.

Behaviour:
- Reset (async, rst=1):
  - PC=RESET_PC.
  - Queue empty; outstanding=0; drop_cnt=0.
  - InstrValidD=0, InstrD=NOP, PCD=0, PCPlus4D=0.
  - imem_req_valid=0 while rst is high.
- Credit rule: imem_req_valid = !Redirect && (count+outstanding < DEPTH). The queue therefore never overflows and no backpressure is applied to responses.
- Request accept (valid&&ready):
  - outstanding+1.
  - PC+=4, wrapping modulo 2^A_WIDTH.
  - The address of each accepted request is pushed to an internal PC tag FIFO of DEPTH entries.
- Response, drop_cnt=0:
  - Push {data, tag PC} into the queue.
  - Pop the tag FIFO; outstanding-1.
- Response, drop_cnt>0:
  - Discard the data; pop the tag; drop_cnt-1; outstanding-1.
- Dequeue: when InstrValidD && !StallD, the head is consumed at the clock edge.
- No bypass: a response written in cycle N is visible as InstrValidD in cycle N+1.
- Simultaneous push and pop keeps count unchanged; push to a queue that becomes full in the same cycle is legal.
- Redirect=1 (highest priority):
  - Queue cleared and no dequeue counted.
  - PC=RedirectTarget.
  - Request gated off that cycle.
  - drop_cnt = outstanding after this cycle's response accounting. Any same-cycle response is handled under the pre-redirect drop rules.
  - Tag FIFO is not cleared; stale tags drain with the dropped responses.
- Redirect while drop_cnt>0: drop_cnt accumulates to the new outstanding total.
- The first request of the new stream is issued the cycle after Redirect.
- With a 1-cycle memory, the target instruction reaches InstrValidD 3 cycles after Redirect:
  - Redirect at cycle R.
  - Request at R+1.
  - Response at R+2.
  - Valid at R+3.
- StallD with empty queue: no effect.
- Queue full: requests stop through credit, not through imem_req_ready.
- Reset mid-operation: all state is cleared. In-flight responses arriving after reset are the memory's responsibility; memory is reset by the same rst.

Decomposition:
- Package fetch_pkg holds:
  - NOP_INSTR = 32'h0000_0013.
  - RESET_PC default.
  - A typedef for a queue entry struct {instr, pc}.
- One sub-module: fetch_fifo, a synchronous FIFO.
  - Parameterised WIDTH/DEPTH.
  - Has push, pop, flush, full, empty and count.
  - Instantiated twice: the instruction queue (flush on Redirect) and the PC tag FIFO (no flush).
- fetch_queue itself holds the PC, the outstanding and drop counters, and the credit logic.

Test Plan:
- Release reset, 1-cycle memory always ready, StallD=0.
  - imem_addr is 0,4,8,…
  - InstrValidD first rises 2 cycles after the first accept.
  - PCD/InstrD track addresses 0,4,8 with one entry per cycle; PCPlus4D=PCD+4.
- Hold StallD=1 for 10 cycles.
  - Requests stop after DEPTH total in queue/flight.
  - Head holds PCD=0 and InstrD unchanged.
  - Release: entries 0,4,8,12 then 16 are delivered in order with no loss or duplication.
- Memory with 3-cycle latency, 2 requests outstanding, Redirect to 0x100.
  - Both stale responses are dropped.
  - Next valid PCD=0x100 and InstrD equals mem[0x100].
- Redirect in the same cycle as a response and a dequeue.
  - Queue empties, InstrValidD=0 next cycle, InstrD=NOP.
  - First delivered PCD=target.
- Two back-to-back Redirects (0x200, then 0x300 the next cycle).
  - No instruction from 0x200 is ever delivered; first PCD=0x300.
- Assert rst asynchronously mid-stream with the queue non-empty.
  - InstrValidD=0 immediately, without waiting for a clock edge.
  - After release, fetch restarts at RESET_PC.
